// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: signed scan coordinates, sync/de decode,
// line/frame strobes and frame counter, all delayed through a PIPE-deep output pipeline.
module vga_timing_gen #(
  parameter int CORDW  = 16,
  parameter int H_W    = 640,
  parameter int H_FP   = 16,
  parameter int H_PW   = 96,
  parameter int H_BP   = 48,
  parameter int V_H    = 480,
  parameter int V_FP   = 10,
  parameter int V_PW   = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIPE   = 1,
  parameter int FCW    = 16
) (
  input  logic                    pix_clk,
  input  logic                    pix_rst,
  input  logic                    en,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [FCW-1:0]          frame_cnt
);

  localparam int H_STA  = -(H_FP + H_PW + H_BP);
  localparam int HS_STA = H_STA + H_FP;
  localparam int HS_END = HS_STA + H_PW;
  localparam int V_STA  = -(V_FP + V_PW + V_BP);
  localparam int VS_STA = V_STA + V_FP;
  localparam int VS_END = VS_STA + V_PW;

  localparam longint C_MAX = (longint'(1) <<< (CORDW - 1)) - 1;
  localparam longint C_MIN = -C_MAX - 1;

  generate
    if (PIPE < 1) begin : g_chk_pipe
      $error("vga_timing_gen: PIPE must be at least 1");
    end
    if (longint'(H_STA) < C_MIN || longint'(V_STA) < C_MIN ||
        longint'(H_W - 1) > C_MAX || longint'(V_H - 1) > C_MAX) begin : g_chk_cordw
      $error("vga_timing_gen: CORDW too narrow for the configured timing");
    end
  endgenerate

  localparam logic signed [CORDW-1:0] X_STA  = CORDW'(H_STA);
  localparam logic signed [CORDW-1:0] X_LAST = CORDW'(H_W - 1);
  localparam logic signed [CORDW-1:0] X_HS0  = CORDW'(HS_STA);
  localparam logic signed [CORDW-1:0] X_HS1  = CORDW'(HS_END);
  localparam logic signed [CORDW-1:0] Y_STA  = CORDW'(V_STA);
  localparam logic signed [CORDW-1:0] Y_LAST = CORDW'(V_H - 1);
  localparam logic signed [CORDW-1:0] Y_VS0  = CORDW'(VS_STA);
  localparam logic signed [CORDW-1:0] Y_VS1  = CORDW'(VS_END);

  typedef struct packed {
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    hs;
    logic                    vs;
    logic                    de;
    logic                    ls;
    logic                    fs;
    logic [FCW-1:0]          fc;
  } stage_t;

  localparam stage_t RST_S = '{x: '0, y: '0, hs: ~HS_POL, vs: ~VS_POL,
                               de: 1'b0, ls: 1'b0, fs: 1'b0, fc: '0};

  logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  stage_t                  s0;
  stage_t                  pipe_q [PIPE];

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    fcnt_d = fcnt_q;
    if (en) begin
      if (x_q == X_LAST) begin
        x_d = X_STA;
        if (y_q == Y_LAST) begin
          y_d    = Y_STA;
          fcnt_d = fcnt_q + FCW'(1);
        end else begin
          y_d = y_q + CORDW'(1);
        end
      end else begin
        x_d = x_q + CORDW'(1);
      end
    end

    // Syncs follow the held position even while en is low; strobes and de do not.
    s0    = RST_S;
    s0.x  = x_q;
    s0.y  = y_q;
    s0.hs = (x_q >= X_HS0 && x_q < X_HS1) ? HS_POL : ~HS_POL;
    s0.vs = (y_q >= Y_VS0 && y_q < Y_VS1) ? VS_POL : ~VS_POL;
    s0.de = en && !x_q[CORDW-1] && !y_q[CORDW-1];
    s0.ls = en && (x_q == X_STA);
    s0.fs = en && (x_q == X_STA) && (y_q == Y_STA);
    s0.fc = fcnt_q;
  end

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      x_q    <= X_STA;
      y_q    <= Y_STA;
      fcnt_q <= '0;
      for (int unsigned i = 0; i < PIPE; i++) pipe_q[i] <= RST_S;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      fcnt_q    <= fcnt_d;
      pipe_q[0] <= s0;
      for (int unsigned i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign sx          = pipe_q[PIPE-1].x;
  assign sy          = pipe_q[PIPE-1].y;
  assign hsync       = pipe_q[PIPE-1].hs;
  assign vsync       = pipe_q[PIPE-1].vs;
  assign de          = pipe_q[PIPE-1].de;
  assign line_start  = pipe_q[PIPE-1].ls;
  assign frame_start = pipe_q[PIPE-1].fs;
  assign frame_cnt   = pipe_q[PIPE-1].fc;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised pixel-timing generator: the next generation of the scan generator feeding the renderer and the LCD/VGA output stage.
- Timings are module parameters rather than config-header branches.
- Adds sync polarity control, a configurable output pipeline delay for aligning with multi-stage pixel pipelines, a scan enable, line/frame start strobes and a frame counter.
- Coordinates are signed: blanking region is negative, the active area is 0..H_W-1 / 0..V_H-1.

Parameters:
CORDW, 16, coordinate width (signed)
H_W, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_PW, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_H, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_PW, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
PIPE, 1, output latency in cycles (>=1)
FCW, 16, frame counter width

Ports:
pix_clk  in  1  pixel clock; single clock domain
pix_rst  in  1  synchronous reset, active-high
en  in  1  scan enable; counters advance only when high
sx  out  CORDW  signed horizontal position
sy  out  CORDW  signed vertical position
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  data enable, active area
line_start  out  1  one-cycle strobe on the first pixel of each line
frame_start  out  1  one-cycle strobe on the first pixel of each frame
frame_cnt  out  FCW  completed-frame count, wraps modulo 2^FCW

Behaviour:
- Derived constants:
  - H_STA = -(H_FP+H_PW+H_BP); HS_STA = H_STA+H_FP; HS_END = HS_STA+H_PW.
  - V_STA = -(V_FP+V_PW+V_BP); VS_STA = V_STA+V_FP; VS_END = VS_STA+V_PW.
- Elaboration: $error if PIPE<1 or CORDW cannot represent H_STA, V_STA, H_W-1 and V_H-1.
- Internal counters pos_x, pos_y:
  - Reset: pos_x=H_STA, pos_y=V_STA.
  - en high: pos_x increments; at H_W-1 it wraps to H_STA and pos_y increments; pos_y at V_H-1 wraps to V_STA.
  - en low: both counters hold.
- Frame counter: increments when en=1 and pos=(H_W-1, V_H-1). The wrap from 2^FCW-1 to 0 is silent.
- Stage-0 decode (combinational from pos):
  - hsync active iff HS_STA <= pos_x < HS_END.
  - vsync active iff VS_STA <= pos_y < VS_END.
  - de = en and pos_x>=0 and pos_y>=0.
  - line_start = en and pos_x==H_STA.
  - frame_start = line_start and pos_y==V_STA.
  - All comparisons are signed.
- Output pipeline: stage-0 values, plus pos and the frame counter, pass through PIPE register stages.
  - Every output for a position appears exactly PIPE cycles after the counters hold that position; all outputs stay mutually aligned.
  - PIPE=1 gives one-cycle registered output.
- Reset values of every pipeline stage and output: sx=0, sy=0, hsync=~HS_POL, vsync=~VS_POL, de=0, line_start=0, frame_start=0, frame_cnt=0.
- First frame: the first cycle with pix_rst low has pos=(H_STA,V_STA). frame_start is asserted at the outputs PIPE cycles later, provided en=1.
- frame_cnt alongside frame_start equals the number of frames completed before that frame, so the first frame shows 0.
- Reset mid-frame: counters return to (H_STA,V_STA) and the pipeline clears on the same edge; the next frame restarts cleanly with frame_cnt=0.
- en low mid-line:
  - Syncs keep reflecting the held position.
  - de, line_start and frame_start are 0 for held cycles.
  - On re-enable the scan resumes from the held position, with no skipped or duplicated pixels.
- Line period = H_W+H_FP+H_PW+H_BP cycles; frame = (V_H+V_FP+V_PW+V_BP) lines (defaults: 800 cycles, 525 lines, 420000 cycles).

Test Plan:
1. Reset held for 5 cycles, defaults -> all outputs at reset values; after release with en=1, frame_start=1, line_start=1, sx=-160, sy=-45, frame_cnt=0 one cycle later.
2. Defaults, one line -> hsync low for exactly 96 cycles starting at sx=-144; de high for 640 consecutive cycles with sx 0..639; line_start every 800 cycles.
3. Defaults, two frames -> frame_start spacing 420000 cycles; vsync low exactly for sy=-35..-34 (1600 cycles); frame_cnt 0 then 1; 307200 de cycles per frame.
4. PIPE=3, HS_POL=1 -> every output lags the PIPE=1 reference by exactly 2 cycles; hsync high only during the pulse.
5. en dropped for 10 cycles at sx=100 -> de=0 for those 10 cycles; sx resumes at 101 after re-enable; frame period extends by 10.
6. FCW=2, run 5 frames; assert pix_rst at sy=200 -> frame_cnt sequence 0,1,2,3,0; after reset, the next frame_start shows frame_cnt=0 at sx=-160, sy=-45.
